// File: rtl/dev_window_avg.sv
// Floor-rounded mean of the last 2**LOG2_N signed samples; one register stage from accept to result.
// A pending unconsumed result blocks new input unless it is consumed on the same edge (in_ready = !avg_valid || avg_ready).
module dev_window_avg #(
  parameter int WIDTH  = 20,
  parameter int LOG2_N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] D_out,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] avg_out,
  output logic             avg_valid,
  input  logic             avg_ready,
  output logic             filled
);

  localparam int N  = 1 << LOG2_N;
  localparam int SW = WIDTH + LOG2_N;
  localparam logic [LOG2_N:0] CNT_LAST = (LOG2_N + 1)'(N - 1);

  typedef enum logic {FILL, RUN} state_t;

  state_t                state;
  logic [WIDTH-1:0]      mem [N];
  logic [LOG2_N-1:0]     wp;
  logic [LOG2_N:0]       cnt;
  logic signed [SW-1:0]  sum;
  logic signed [SW-1:0]  sum_next;
  logic signed [SW-1:0]  din_ext;
  logic signed [SW-1:0]  old_ext;
  logic                  accept;
  logic                  completes;
  logic                  emit;

  assign in_ready  = !avg_valid || avg_ready;
  assign accept    = in_valid && in_ready;
  assign completes = (state == FILL) && (cnt == CNT_LAST);
  assign emit      = accept && ((state == RUN) || completes);

  assign din_ext  = {{LOG2_N{D_out[WIDTH-1]}}, D_out};
  // Stale entries left over from before a restart must not leave the sum while filling.
  assign old_ext  = (state == RUN) ? {{LOG2_N{mem[wp][WIDTH-1]}}, mem[wp]} : '0;
  assign sum_next = sum + din_ext - old_ext;

  always_ff @(posedge clk) begin
    if (!rst && !clear && accept) begin
      mem[wp] <= D_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state     <= FILL;
      wp        <= '0;
      cnt       <= '0;
      sum       <= '0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
      filled    <= 1'b0;
    end else begin
      if (accept) begin
        wp  <= wp + 1'b1;
        sum <= sum_next;
        if (state == FILL) begin
          cnt <= cnt + 1'b1;
        end
        if (completes) begin
          state  <= RUN;
          filled <= 1'b1;
        end
      end
      // Floor of the mean is just the upper WIDTH bits of the window sum.
      if (emit) begin
        avg_out   <= sum_next[SW-1:LOG2_N];
        avg_valid <= 1'b1;
      end else if (avg_ready) begin
        avg_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dev_window_avg.sv
// Bench for dev_window_avg: queue-based window model compared every cycle, plus directed literal checks
// and a randomized phase with random handshakes, clears and resets.
module tb_dev_window_avg;

  localparam int W = 20;
  localparam int L = 3;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic [W-1:0] D_out;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] avg_out;
  logic         avg_valid;
  logic         avg_ready;
  logic         filled;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dev_window_avg #(.WIDTH(W), .LOG2_N(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .D_out     (D_out),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .avg_out   (avg_out),
    .avg_valid (avg_valid),
    .avg_ready (avg_ready),
    .filled    (filled)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: samples accepted since the last restart, latest N kept.
  int                  hist[$];
  int                  exp_out   = 0;
  bit                  exp_valid = 1'b0;
  bit                  started   = 1'b0;
  bit                  acc;
  logic signed [W-1:0] smp;

  function automatic int floor_mean();
    longint s = 0;
    longint q;
    foreach (hist[i]) s += hist[i];
    q = s / N;
    if (s < 0 && q * N != s) q = q - 1;
    return int'(q);
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    if (rst || clear) begin
      hist.delete();
      exp_valid = 1'b0;
      exp_out   = 0;
    end else begin
      acc = in_valid && (!exp_valid || avg_ready);
      if (acc) begin
        smp = D_out;
        hist.push_back(int'(smp));
        if (hist.size() > N) void'(hist.pop_front());
      end
      if (acc && hist.size() == N) begin
        exp_out   = floor_mean();
        exp_valid = 1'b1;
      end else if (avg_ready) begin
        exp_valid = 1'b0;
      end
    end
  end

  logic [W-1:0] exp_out_w;
  always @(negedge clk) begin
    if (started) begin
      exp_out_w = exp_out[W-1:0];
      check("avg_valid", avg_valid, exp_valid);
      check("avg_out",   avg_out,   exp_out_w);
      check("filled",    filled,    hist.size() == N);
      check("in_ready",  in_ready,  !exp_valid || avg_ready);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [W-1:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    D_out    = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = in_ready;
      tick();
    end
    check("send_accepted", ok, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic restart();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  logic [W-1:0] v;

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; avg_ready = 1'b1; D_out = '0;
    tick(); tick();
    check("rst_avg_out", avg_out, 20'h00000);
    check("rst_avg_valid", avg_valid, 1'b0);
    check("rst_filled", filled, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_avg_out", avg_out, 20'h00000);
    check("clr_avg_valid", avg_valid, 1'b0);
    check("clr_filled", filled, 1'b0);
    check("clr_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 8; i++) begin
      send(20'h01000);
      if (i < 7) check("fill_no_valid", avg_valid, 1'b0);
    end
    check("fill_avg_out", avg_out, 20'h01000);
    check("fill_filled", filled, 1'b1);
    check("fill_valid", avg_valid, 1'b1);

    send(20'h09000);
    check("slide_avg_out", avg_out, 20'h02000);
    v = 20'hF8000;
    for (int i = 0; i < 72; i++) begin
      send(v);
      v = v + 20'h01000;
    end

    restart();
    for (int i = 0; i < 7; i++) send(20'hFFFFF);
    send(20'h00000);
    check("floor_neg", avg_out, 20'hFFFFF);

    restart();
    for (int i = 0; i < 8; i++) send(20'h7FFFF);
    check("max_pos", avg_out, 20'h7FFFF);
    for (int i = 0; i < 8; i++) send(20'h80000);
    check("max_neg", avg_out, 20'h80000);

    avg_ready = 1'b0;
    in_valid  = 1'b1;
    D_out     = 20'h10000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_hold", avg_out, 20'h80000);
    end
    avg_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp_release", avg_out, 20'h92000);
    tick();
    check("bp_no_dup", avg_valid, 1'b0);

    send(20'h00100);
    send(20'h00200);
    clear = 1'b1; in_valid = 1'b1; D_out = 20'h7FFFF;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check("mid_clear_valid", avg_valid, 1'b0);
    check("mid_clear_filled", filled, 1'b0);
    for (int i = 0; i < 7; i++) begin
      send(20'h00010);
      check("refill_no_valid", avg_valid, 1'b0);
    end
    send(20'h00010);
    check("refill_valid", avg_valid, 1'b1);
    check("refill_avg_out", avg_out, 20'h00010);

    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      avg_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0:       D_out = 20'h7FFFF;
        1:       D_out = 20'h80000;
        default: D_out = 20'($urandom());
      endcase
      clear = ($urandom_range(0, 99) == 0);
      rst   = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; avg_ready = 1'b1;
    tick(); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dev_window_avg.md
# dev_window_avg

Streaming moving-average stage placed directly downstream of `dev`. It consumes the signed 20-bit `D_out` sample stream over a valid/ready handshake and keeps the last N samples in a circular buffer. For every accepted sample, once the window is full, it emits the exact window mean, rounded toward negative infinity, through a one-entry output register with backpressure.

## Interface

Parameters:

- `WIDTH`, 20: sample width, signed two's complement. Matches `D_out`.
- `LOG2_N`, 3: log2 of the window length. N = 2^LOG2_N = 8. Legal range 1..6.

Ports:

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clear`  in  1  synchronous window restart; same effect as `rst` but lower priority.
- `D_out`  in  WIDTH  signed input sample, from `dev`.
- `in_valid`  in  1  `D_out` holds a sample.
- `in_ready`  out  1  stage can accept a sample this cycle.
- `avg_out`  out  WIDTH  signed window mean.
- `avg_valid`  out  1  `avg_out` holds an unconsumed result.
- `avg_ready`  in  1  consumer takes `avg_out` this cycle.
- `filled`  out  1  window holds N samples; the stage is in RUN.

## Operation

- Accept: a sample is accepted on a rising edge where `in_valid && in_ready`.
- `in_ready = !avg_valid || avg_ready`. This is combinational, and is the only combinational input-to-output path.
- Storage:
  - N-entry buffer, WIDTH bits per entry.
  - Write pointer `wp`, LOG2_N bits. It wraps from N-1 to 0 and advances on every accept.
  - Running sum `sum`, signed WIDTH+LOG2_N bits. It cannot overflow and is never saturated.
- States:
  - FILL, entered after reset or clear, with fill counter `cnt` = 0.
    - Each accept writes `buf[wp]` and adds the sample to `sum`.
    - The old buffer contents are ignored.
    - `cnt` increments on each accept.
    - On the accept that makes `cnt` reach N: go to RUN, and produce an output on that same accept.
  - RUN: each accept computes `sum_next = sum + D_out - buf[wp]`, then writes `buf[wp] = D_out` and `sum = sum_next`.
- Output:
  - On every accept that leaves the stage in RUN, including the FILL-to-RUN accept, `avg_out <= sum_next >>> LOG2_N` and `avg_valid <= 1`.
  - The shift is arithmetic, i.e. floor.
  - The result always fits in WIDTH bits, so no saturation is needed.
- Output hold: while `avg_valid && !avg_ready`, `avg_out` is held stable and no new sample is accepted (`in_ready` = 0).
- Drain: if `avg_valid && avg_ready` and there is no accept on that edge, then `avg_valid <= 0`. `avg_out` keeps its last value.
- Simultaneous consume and accept: an edge where `avg_ready` and an accept both occur, in RUN, loads the new result and `avg_valid` stays 1. There is no bubble.
- FILL accepts that do not complete the window change neither `avg_valid` nor `avg_out`, apart from the drain rule above.
- Reset and clear:
  - `rst` or `clear`: `avg_out` = 0, `avg_valid` = 0, `filled` = 0, `cnt` = 0, `wp` = 0, `sum` = 0, state FILL.
  - The buffer contents are not cleared.
  - Any input offered on the same edge is dropped.
  - Any pending output is discarded even if `avg_ready` = 1.
- `filled` = 1 exactly when the state is RUN.

## Timing

- Latency: a sample accepted on edge k produces `avg_out`/`avg_valid` visible after edge k. That is one register stage; `D_out` has no combinational path to `avg_out`.
- Throughput: one sample per cycle while `avg_ready` = 1 or no result is pending.
- First result: after the Nth accept following reset or clear.
- Reset values:
  - `avg_out` = 0
  - `avg_valid` = 0
  - `filled` = 0
  - `in_ready` = 1, because it follows `!avg_valid`.
- Priority: `rst` > `clear` > accept/drain.
- Reset mid-stream: the window restarts from FILL. Results are never mixed across a reset or clear.
- Pointer wrap: `wp` wraps every N accepts. The sliding-window sum must stay exact across arbitrarily many wraps.

## Test plan

- Reset: hold `rst` 2 cycles -> `avg_out` = 0, `avg_valid` = 0, `filled` = 0, `in_ready` = 1. Repeat with `clear` asserted on the release cycle -> same values.
- Fill: 8 back-to-back samples of 20'sh01000 with `avg_ready` = 1 -> `avg_valid` stays 0 through the first 7 accepts. After the 8th: `avg_out` = 20'sh01000, `filled` = 1.
- Slide: continue with 20'sh09000 -> `avg_out` = 20'sh02000. Then 72 samples stepping +20'sh1000 from 20'shF8000 -> each result equals the floor mean of the last 8 inputs, checked against a model.
- Floor rounding: fill with seven 20'shFFFFF and one 20'sh00000 -> `avg_out` = 20'shFFFFF (-7 >>> 3 = -1).
- Extremes: 8 × 20'sh7FFFF -> 20'sh7FFFF. Then 8 × 20'sh80000 -> 20'sh80000, with intermediate results matching the model.
- Backpressure and restart: hold `avg_ready` low 5 cycles in RUN -> `in_ready` = 0, `avg_out` stable, held sample not consumed. Release -> the held sample is accepted on the release edge with no loss or duplication. Then assert `clear` mid-stream -> `avg_valid` = 0, and the next result appears only after 8 new accepts.
